l2_responder: RTL and testbench

- Next-level (L2) responder that serves line-fill reads from the instruction cache and line reads/write-backs from the data cache.
- It is the memory-side end of the cache-to-L2 interface: the L1 caches initiate, this block arbitrates, waits a fixed latency, then acknowledges with a 512-bit line.
- It contains a modelled backing store plus fill and write-back counters consumed by the stats block.

---
 rtl/l2_pkg.sv | 28 ++
 rtl/l2_line_store.sv | 52 +++++
 rtl/l2_responder.sv | 162 ++++++++++++++++
 tb/tb_l2_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared widths, FSM state type and the miss-pattern generator for the L2 responder.
package l2_pkg;

  localparam int unsigned LINE_BITS      = 512;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned OFFSET_BITS    = 6;
  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned ADDR_BITS      = 32;
  localparam int unsigned LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int unsigned STAT_BITS      = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Each word of an unbacked line reads back as its own byte address.
  function automatic logic [LINE_BITS-1:0] pattern_line(input logic [LINE_ADDR_BITS-1:0] line_addr);
    logic [LINE_BITS-1:0] line;
    line = '0;
    for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
      line[w*WORD_BITS +: WORD_BITS] = {line_addr, 4'(w), 2'b00};
    end
    return line;
  endfunction

endpackage

// File: rtl/l2_line_store.sv
// Direct-mapped backing store: tag/valid/data array, combinational read, pattern on miss.
module l2_line_store
  import l2_pkg::*;
#(
  parameter int unsigned LINES = 64
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic [LINE_ADDR_BITS-1:0] rd_line_add,
  output logic [LINE_BITS-1:0]      rd_line_c,
  input  logic                      wr_en,
  input  logic [LINE_ADDR_BITS-1:0] wr_line_add,
  input  logic [LINE_BITS-1:0]      wr_line
);

  localparam int unsigned IDX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS = LINE_ADDR_BITS - IDX_BITS;

  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tags  [LINES];
  logic [LINE_BITS-1:0] lines [LINES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic [TAG_BITS-1:0] wr_tag;

  assign rd_idx = rd_line_add[IDX_BITS-1:0];
  assign rd_tag = rd_line_add[LINE_ADDR_BITS-1 -: TAG_BITS];
  assign wr_idx = wr_line_add[IDX_BITS-1:0];
  assign wr_tag = wr_line_add[LINE_ADDR_BITS-1 -: TAG_BITS];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_line;
    end
  end

  assign rd_line_c = (valid[rd_idx] && (tags[rd_idx] == rd_tag)) ? lines[rd_idx]
                                                                 : pattern_line(rd_line_add);

endmodule

// File: rtl/l2_responder.sv
// Memory-side end of the L1-to-L2 interface: round-robin arbiter, fixed-latency FSM,
// backing store and saturating fill/write-back counters.
module l2_responder
  import l2_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINES   = 64
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_add,
  output logic                 i_ack,
  output logic [LINE_BITS-1:0] i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_add,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic                 d_ack,
  output logic [LINE_BITS-1:0] d_data,
  output logic                 busy,
  output logic [STAT_BITS-1:0] i_fills,
  output logic [STAT_BITS-1:0] d_fills,
  output logic [STAT_BITS-1:0] d_wbs
);

  localparam int unsigned          CNT_BITS = 8;
  localparam logic [CNT_BITS-1:0]  CNT_LOAD = CNT_BITS'(LATENCY - 1);
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_BITS-1:0]       cnt;
  logic [CNT_BITS-1:0]       cnt_nxt;
  logic                      last_d;
  logic                      grant_c;
  logic                      grant_d_c;
  logic                      resp_go_c;
  logic                      lat_d;
  logic                      lat_we;
  logic [LINE_ADDR_BITS-1:0] lat_line;
  logic [LINE_BITS-1:0]      lat_wdata;
  logic                      cur_d_c;
  logic                      cur_we_c;
  logic [LINE_ADDR_BITS-1:0] cur_line_c;
  logic [LINE_BITS-1:0]      cur_wdata_c;
  logic [LINE_BITS-1:0]      rd_line_c;
  logic                      unused_offset;

  // Byte offset within a line never affects the response.
  assign unused_offset = ^{i_add[OFFSET_BITS-1:0], d_add[OFFSET_BITS-1:0]};

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // WAIT spans LATENCY edges (counter walks LATENCY-1 down to 0, then one more edge).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_c   = 1'b0;
    grant_d_c = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_c   = 1'b1;
          grant_d_c = d_req && (!i_req || !last_d);
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_BITS'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_go_c = (state_nxt == RESP);

  // Grant-cycle bypass lets LATENCY = 1 respond from the live request.
  assign cur_d_c     = grant_c ? grant_d_c : lat_d;
  assign cur_we_c    = grant_c ? (grant_d_c && d_we) : lat_we;
  assign cur_line_c  = grant_c ? (grant_d_c ? d_add[ADDR_BITS-1:OFFSET_BITS]
                                            : i_add[ADDR_BITS-1:OFFSET_BITS])
                               : lat_line;
  assign cur_wdata_c = grant_c ? d_wdata : lat_wdata;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      last_d    <= 1'b0;
      lat_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_line  <= '0;
      lat_wdata <= '0;
    end else if (grant_c) begin
      last_d    <= grant_d_c;
      lat_d     <= cur_d_c;
      lat_we    <= cur_we_c;
      lat_line  <= cur_line_c;
      lat_wdata <= cur_wdata_c;
    end
  end

  l2_line_store #(
    .LINES(LINES)
  ) u_store (
    .clk        (clk),
    .clear_n    (clear_n),
    .rd_line_add(cur_line_c),
    .rd_line_c  (rd_line_c),
    .wr_en      (resp_go_c && cur_d_c && cur_we_c),
    .wr_line_add(cur_line_c),
    .wr_line    (cur_wdata_c)
  );

  // Acks, data and counters all update on the edge that enters RESP.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      busy    <= 1'b0;
      i_data  <= '0;
      d_data  <= '0;
      i_fills <= '0;
      d_fills <= '0;
      d_wbs   <= '0;
    end else begin
      i_ack <= resp_go_c && !cur_d_c;
      d_ack <= resp_go_c && cur_d_c;
      busy  <= (state_nxt != IDLE);
      if (resp_go_c) begin
        if (!cur_d_c) begin
          i_data <= rd_line_c;
          if (i_fills != STAT_MAX) i_fills <= i_fills + STAT_BITS'(1);
        end else if (cur_we_c) begin
          d_data <= cur_wdata_c;
          if (d_wbs != STAT_MAX) d_wbs <= d_wbs + STAT_BITS'(1);
        end else begin
          d_data <= rd_line_c;
          if (d_fills != STAT_MAX) d_fills <= d_fills + STAT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_responder.sv
// Directed bench for l2_responder: latency, store hit/miss, arbitration, reset abort, saturation.
module tb_l2_responder;

  logic         clk;
  logic         clear_n;
  logic         i_req, i_ack, d_req, d_we, d_ack, busy;
  logic [31:0]  i_add, d_add, i_fills, d_fills, d_wbs;
  logic [511:0] i_data, d_wdata, d_data;

  logic         i_req1, i_ack1, d_req1, d_we1, d_ack1, busy1;
  logic [31:0]  i_add1, d_add1, i_fills1, d_fills1, d_wbs1;
  logic [511:0] i_data1, d_wdata1, d_data1;

  int checks;
  int errors;

  l2_responder #(.LATENCY(4), .LINES(64)) dut (
    .clk(clk), .clear_n(clear_n),
    .i_req(i_req), .i_add(i_add), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_add(d_add), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_data(d_data), .busy(busy),
    .i_fills(i_fills), .d_fills(d_fills), .d_wbs(d_wbs)
  );

  l2_responder #(.LATENCY(1), .LINES(4)) dut1 (
    .clk(clk), .clear_n(clear_n),
    .i_req(i_req1), .i_add(i_add1), .i_ack(i_ack1), .i_data(i_data1),
    .d_req(d_req1), .d_we(d_we1), .d_add(d_add1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_data(d_data1), .busy(busy1),
    .i_fills(i_fills1), .d_fills(d_fills1), .d_wbs(d_wbs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input logic [31:0] a);
    logic [511:0] l;
    l = '0;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = {a[31:6], 4'(w), 2'b00};
    return l;
  endfunction

  // One transaction on the LATENCY=4 instance; cyc counts edges from sampling edge (1) to ack.
  task automatic xfer(input logic is_d, input logic we, input logic [31:0] add,
                      input logic [511:0] wdata, output logic [511:0] line, output int cyc);
    cyc  = 0;
    line = '0;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_add = add; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_add = add;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        cyc  = c;
        line = is_d ? d_data : i_data;
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic run_tie(input logic [31:0] ia, input logic [31:0] da,
                         output int ti, output int td,
                         output logic [511:0] li, output logic [511:0] ld);
    ti = 0; td = 0; li = '0; ld = '0;
    @(posedge clk); #1;
    i_req = 1'b1; i_add = ia; d_req = 1'b1; d_we = 1'b0; d_add = da;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ti != 0) i_req = 1'b0;
      if (td != 0) d_req = 1'b0;
      if (ti != 0 && td != 0) break;
      @(negedge clk);
      if (i_ack) begin ti = c; li = i_data; end
      if (d_ack) begin td = c; ld = d_data; end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_reset;
    clear_n = 1'b0;
    @(negedge clk);
    checks++; if ({i_ack, d_ack, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b required 000", {i_ack, d_ack, busy}); end
    checks++; if ({i_data, d_data} !== '0) begin errors++; $display("FAIL reset_data: got nonzero required 0"); end
    checks++; if ({i_fills, d_fills, d_wbs} !== 96'h0) begin errors++; $display("FAIL reset_counters: got %h required 0", {i_fills, d_fills, d_wbs}); end
    @(posedge clk); #1;
    clear_n = 1'b1;
  endtask

  task automatic test_i_read;
    logic [511:0] l; int cyc;
    xfer(1'b0, 1'b0, 32'h0000_1040, '0, l, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL i_latency: got %0d required 5", cyc); end
    checks++; if (l[31:0] !== 32'h0000_1040) begin errors++; $display("FAIL i_word0: got %h required 00001040", l[31:0]); end
    checks++; if (l[511:480] !== 32'h0000_107C) begin errors++; $display("FAIL i_word15: got %h required 0000107c", l[511:480]); end
    @(negedge clk);
    checks++; if ({i_ack, busy} !== 2'b00) begin errors++; $display("FAIL i_ack_pulse: got %b required 00", {i_ack, busy}); end
    checks++; if (i_fills !== 32'd1) begin errors++; $display("FAIL i_fills: got %0d required 1", i_fills); end
  endtask

  task automatic test_write_read;
    logic [511:0] l; int cyc;
    xfer(1'b1, 1'b1, 32'h0000_2000, {16{32'hDEAD_BEEF}}, l, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL wb_latency: got %0d required 5", cyc); end
    checks++; if (l !== {16{32'hDEAD_BEEF}}) begin errors++; $display("FAIL wb_echo: got %h required all deadbeef", l); end
    xfer(1'b1, 1'b0, 32'h0000_2000, '0, l, cyc);
    checks++; if (l !== {16{32'hDEAD_BEEF}}) begin errors++; $display("FAIL rd_after_wb: got %h required all deadbeef", l); end
    checks++; if ({d_wbs, d_fills} !== {32'd1, 32'd1}) begin errors++; $display("FAIL d_counters: got wbs=%0d fills=%0d required 1 1", d_wbs, d_fills); end
    checks++; if (i_data !== pat(32'h0000_1040)) begin errors++; $display("FAIL i_data_hold: got %h required %h", i_data, pat(32'h0000_1040)); end
    xfer(1'b0, 1'b0, 32'h0001_2000, '0, l, cyc);
    checks++; if (l !== pat(32'h0001_2000)) begin errors++; $display("FAIL alias_tag: got %h required %h", l, pat(32'h0001_2000)); end
    checks++; if (d_data !== {16{32'hDEAD_BEEF}}) begin errors++; $display("FAIL d_data_hold: got %h required all deadbeef", d_data); end
  endtask

  task automatic test_arbitration;
    int ti, td, cyc; logic [511:0] li, ld, l;
    run_tie(32'h0000_5040, 32'h0000_4000, ti, td, li, ld);
    checks++; if (td !== 5) begin errors++; $display("FAIL tie1_d_first: got %0d required 5", td); end
    checks++; if (ti !== 11) begin errors++; $display("FAIL tie1_i_gap: got %0d required 11", ti); end
    checks++; if (ld !== pat(32'h0000_4000)) begin errors++; $display("FAIL tie1_d_data: got %h required %h", ld, pat(32'h0000_4000)); end
    checks++; if (li !== pat(32'h0000_5040)) begin errors++; $display("FAIL tie1_i_data: got %h required %h", li, pat(32'h0000_5040)); end
    xfer(1'b1, 1'b0, 32'h0000_4000, '0, l, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL solo_d_latency: got %0d required 5", cyc); end
    run_tie(32'h0000_6000, 32'h0000_7000, ti, td, li, ld);
    checks++; if (ti !== 5) begin errors++; $display("FAIL tie2_i_first: got %0d required 5", ti); end
    checks++; if (td !== 11) begin errors++; $display("FAIL tie2_d_gap: got %0d required 11", td); end
    checks++; if ({i_fills, d_fills, d_wbs} !== {32'd4, 32'd4, 32'd1}) begin errors++; $display("FAIL arb_counters: got %h required 000000040000000400000001", {i_fills, d_fills, d_wbs}); end
  endtask

  task automatic test_latency1;
    int ack_c, acks, nbusy; logic [511:0] l;
    ack_c = 0; acks = 0; nbusy = 0; l = '0;
    @(posedge clk); #1;
    i_req1 = 1'b1; i_add1 = 32'h0000_0040;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (ack_c != 0) i_req1 = 1'b0;
      @(negedge clk);
      if (i_ack1) begin acks++; if (ack_c == 0) begin ack_c = c; l = i_data1; end end
      if (busy1) nbusy++;
    end
    checks++; if (ack_c !== 1) begin errors++; $display("FAIL l1_latency: got %0d required 1", ack_c); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL l1_ack_count: got %0d required 1", acks); end
    checks++; if (nbusy !== 1) begin errors++; $display("FAIL l1_busy_cycles: got %0d required 1", nbusy); end
    checks++; if (l !== pat(32'h0000_0040)) begin errors++; $display("FAIL l1_data: got %h required %h", l, pat(32'h0000_0040)); end
    checks++; if (i_fills1 !== 32'd1) begin errors++; $display("FAIL l1_fills: got %0d required 1", i_fills1); end
    checks++; if ({d_ack1, d_fills1, d_wbs1} !== 65'h0 || d_data1 !== '0) begin errors++; $display("FAIL l1_d_idle: got ack=%b fills=%0d wbs=%0d", d_ack1, d_fills1, d_wbs1); end
  endtask

  task automatic test_reset_mid;
    int nacks, cyc; logic [511:0] l;
    nacks = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_add = 32'h0000_3000; d_wdata = {16{32'hA5A5_5A5A}};
    @(posedge clk);
    @(posedge clk); #1;
    clear_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++; if ({busy, d_ack} !== 2'b00) begin errors++; $display("FAIL abort_ctrl: got %b required 00", {busy, d_ack}); end
    checks++; if ({i_fills, d_fills, d_wbs} !== 96'h0) begin errors++; $display("FAIL abort_counters: got %h required 0", {i_fills, d_fills, d_wbs}); end
    @(posedge clk); #1;
    clear_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_ack || busy) nacks++;
    end
    checks++; if (nacks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d active cycles required 0", nacks); end
    xfer(1'b1, 1'b0, 32'h0000_3000, '0, l, cyc);
    checks++; if (l !== pat(32'h0000_3000)) begin errors++; $display("FAIL abort_store: got %h required %h", l, pat(32'h0000_3000)); end
    xfer(1'b1, 1'b0, 32'h0000_2000, '0, l, cyc);
    checks++; if (l !== pat(32'h0000_2000)) begin errors++; $display("FAIL valid_cleared: got %h required %h", l, pat(32'h0000_2000)); end
    checks++; if ({d_fills, d_wbs} !== {32'd2, 32'd0}) begin errors++; $display("FAIL post_abort_counters: got fills=%0d wbs=%0d required 2 0", d_fills, d_wbs); end
  endtask

  task automatic test_saturation;
    int cyc; logic [511:0] l;
    @(negedge clk);
    force dut.d_fills = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.d_fills;
    xfer(1'b1, 1'b0, 32'h0000_0080, '0, l, cyc);
    checks++; if (d_fills !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_fills: got %h required ffffffff", d_fills); end
    checks++; if (l !== pat(32'h0000_0080)) begin errors++; $display("FAIL sat_data: got %h required %h", l, pat(32'h0000_0080)); end
    xfer(1'b1, 1'b0, 32'h0000_00C0, '0, l, cyc);
    checks++; if ({d_fills, d_wbs} !== {32'hFFFF_FFFF, 32'd0}) begin errors++; $display("FAIL sat_hold: got fills=%h wbs=%0d required ffffffff 0", d_fills, d_wbs); end
  endtask

  initial begin
    checks = 0; errors = 0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; i_add = '0; d_add = '0; d_wdata = '0;
    i_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0; i_add1 = '0; d_add1 = '0; d_wdata1 = '0;
    test_reset();
    test_i_read();
    test_write_read();
    test_arbitration();
    test_latency1();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
